// File: rtl/scanline_pos_gen_pkg.sv
// Shared video/scaling constants and helpers for the scanline position generator.
// Mirrors the constants that live in n64adv_vparams.vh.
package scanline_pos_gen_pkg;

    localparam int unsigned COLOR_WIDTH_O = 8;
    localparam int unsigned VSCALE_STEP_W = 12;
    localparam int unsigned VSCALE_FRAC_W = 8;
    localparam int unsigned SL_SRC_LINE_W = 11;
    localparam int unsigned VSCALE_ACC_W  = SL_SRC_LINE_W + VSCALE_FRAC_W;
    localparam logic [VSCALE_STEP_W-1:0] VSCALE_1TO1 = 12'h100;

    typedef enum logic {
        WAIT_FS,
        TRACK
    } sl_state_e;

    // Adds one line step; the integer part clamps at all-ones and the whole value freezes there.
    function automatic logic [VSCALE_ACC_W-1:0] acc_add_sat(
        input logic [VSCALE_ACC_W-1:0]  acc,
        input logic [VSCALE_STEP_W-1:0] step
    );
        logic [VSCALE_ACC_W:0] sum;
        sum = {1'b0, acc} + (VSCALE_ACC_W+1)'(step);
        if (&acc[VSCALE_ACC_W-1:VSCALE_FRAC_W])
            acc_add_sat = acc;
        else if (sum[VSCALE_ACC_W])
            acc_add_sat = {{SL_SRC_LINE_W{1'b1}}, sum[VSCALE_FRAC_W-1:0]};
        else
            acc_add_sat = sum[VSCALE_ACC_W-1:0];
    endfunction

endpackage

// File: rtl/scanline_pos_gen_if.sv
// Video-in / video-out / scanline-position bundle for scanline_pos_gen.
interface scanline_pos_gen_if
    import scanline_pos_gen_pkg::*;
#(
    parameter int unsigned color_width_o = COLOR_WIDTH_O
);
    logic                       HSYNC_i;
    logic                       VSYNC_i;
    logic                       DE_i;
    logic [3*color_width_o-1:0] vdata_i;
    logic [VSCALE_STEP_W-1:0]   vscale_step_i;
    logic [VSCALE_FRAC_W-1:0]   vphase_init_i;

    logic                       HSYNC_o;
    logic                       VSYNC_o;
    logic                       DE_o;
    logic [3*color_width_o-1:0] vdata_o;
    logic [VSCALE_FRAC_W-1:0]   sl_rel_pos_o;
    logic [SL_SRC_LINE_W-1:0]   sl_src_line_o;
    logic                       sl_valid_o;

    modport master (
        output HSYNC_i, VSYNC_i, DE_i, vdata_i, vscale_step_i, vphase_init_i,
        input  HSYNC_o, VSYNC_o, DE_o, vdata_o, sl_rel_pos_o, sl_src_line_o, sl_valid_o
    );

    modport slave (
        input  HSYNC_i, VSYNC_i, DE_i, vdata_i, vscale_step_i, vphase_init_i,
        output HSYNC_o, VSYNC_o, DE_o, vdata_o, sl_rel_pos_o, sl_src_line_o, sl_valid_o
    );
endinterface

// File: rtl/scanline_pos_gen_vid_delay_line.sv
// Parameterised N-stage register pipeline used to delay sync, DE and pixel data.
module vid_delay_line #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 1
) (
    input  logic         VCLK_i,
    input  logic         VRST_i,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] pipe [N];

    always_ff @(posedge VCLK_i) begin
        if (VRST_i) begin
            for (int unsigned i = 0; i < N; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int unsigned i = 1; i < N; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[N-1];

endmodule

// File: rtl/scanline_pos_gen.sv
// Vertical phase tracker: accumulates a 4.8 scale step per output line and emits the
// relative position / source-line index aligned with the 2-cycle delayed video.
module scanline_pos_gen
    import scanline_pos_gen_pkg::*;
#(
    parameter bit          VSYNC_ACT_HIGH = 1'b1,
    parameter int unsigned color_width_o  = COLOR_WIDTH_O
) (
    input  logic                VCLK_i,
    input  logic                VRST_i,
    scanline_pos_gen_if.slave   vid
);

    localparam int unsigned VID_W = 3 + 3*color_width_o;

    logic [VID_W-1:0] vid_dly;

    vid_delay_line #(
        .N(2),
        .W(VID_W)
    ) u_vid_delay_line (
        .VCLK_i (VCLK_i),
        .VRST_i (VRST_i),
        .din    ({vid.HSYNC_i, vid.VSYNC_i, vid.DE_i, vid.vdata_i}),
        .dout   (vid_dly)
    );

    assign {vid.HSYNC_o, vid.VSYNC_o, vid.DE_o, vid.vdata_o} = vid_dly;

    // Stage 1: registered controls; the second vs/de flop gives the previous registered value.
    logic                     vs_act_q1, vs_act_q2;
    logic                     de_q1, de_q2;
    logic [VSCALE_STEP_W-1:0] step_q1;
    logic [VSCALE_FRAC_W-1:0] init_q1;
    logic                     fs, le;

    always_ff @(posedge VCLK_i) begin
        if (VRST_i) begin
            vs_act_q1 <= 1'b0;
            vs_act_q2 <= 1'b0;
            de_q1     <= 1'b0;
            de_q2     <= 1'b0;
            step_q1   <= '0;
            init_q1   <= '0;
        end else begin
            vs_act_q1 <= vid.VSYNC_i ~^ VSYNC_ACT_HIGH;
            vs_act_q2 <= vs_act_q1;
            de_q1     <= vid.DE_i;
            de_q2     <= de_q1;
            step_q1   <= vid.vscale_step_i;
            init_q1   <= vid.vphase_init_i;
        end
    end

    assign fs = vs_act_q1 & ~vs_act_q2;
    assign le = de_q2 & ~de_q1;

    // Stage 2: state, accumulator and position outputs.
    sl_state_e                state, state_nxt;
    logic [VSCALE_ACC_W-1:0]  acc, acc_nxt;
    logic [VSCALE_FRAC_W-1:0] rel_pos_q;
    logic [SL_SRC_LINE_W-1:0] src_line_q;
    logic                     valid_q;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        unique case (state)
            WAIT_FS: begin
                acc_nxt = '0;
                if (fs) begin
                    state_nxt = TRACK;
                    acc_nxt   = VSCALE_ACC_W'(init_q1);
                end
            end
            TRACK: begin
                if (fs)
                    acc_nxt = VSCALE_ACC_W'(init_q1);
                else if (le)
                    acc_nxt = acc_add_sat(acc, step_q1);
            end
        endcase
    end

    always_ff @(posedge VCLK_i) begin
        if (VRST_i) begin
            state      <= WAIT_FS;
            acc        <= '0;
            rel_pos_q  <= '0;
            src_line_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            valid_q <= (state_nxt == TRACK);
            // de_q1 is the next DE_o, so the position only moves outside the active window.
            if (!de_q1) begin
                rel_pos_q  <= acc_nxt[VSCALE_FRAC_W-1:0];
                src_line_q <= acc_nxt[VSCALE_ACC_W-1:VSCALE_FRAC_W];
            end
        end
    end

    assign vid.sl_rel_pos_o  = rel_pos_q;
    assign vid.sl_src_line_o = src_line_q;
    assign vid.sl_valid_o    = valid_q;

endmodule

// File: tb/tb_scanline_pos_gen.sv
// Scoreboard bench for scanline_pos_gen: per-line expected positions from a closed-form
// model, plus a cycle-level check of the 2-cycle video delay.
module tb_scanline_pos_gen;
    import scanline_pos_gen_pkg::*;

    localparam int unsigned CW     = COLOR_WIDTH_O;
    localparam int unsigned ACTIVE = 4;
    localparam int unsigned HBLANK = 3;

    logic VCLK_i = 1'b0;
    logic VRST_i = 1'b1;
    always #5 VCLK_i = ~VCLK_i;

    scanline_pos_gen_if #(.color_width_o(CW)) vid();

    scanline_pos_gen #(
        .VSYNC_ACT_HIGH(1'b1),
        .color_width_o (CW)
    ) dut (
        .VCLK_i (VCLK_i),
        .VRST_i (VRST_i),
        .vid    (vid)
    );

    typedef struct {
        logic [7:0]  pos;
        logic [10:0] line;
        logic        valid;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    bit          tracked  = 1'b0;
    logic [7:0]  cur_init = '0;
    logic [11:0] cur_step = '0;
    int unsigned cur_k    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Phase of line k: init + k*step, integer part clamped at 2047 and frozen from then on.
    function automatic logic [18:0] model_acc(input logic [7:0] init, input logic [11:0] step,
                                              input int unsigned k);
        longint v;
        v = 0;
        for (int unsigned j = 0; j <= k; j++) begin
            v = longint'(init) + longint'(j) * longint'(step);
            if (v / 256 >= 2047)
                return {11'h7FF, v[7:0]};
        end
        return v[18:0];
    endfunction

    function automatic exp_t expect_line();
        exp_t        e;
        logic [18:0] a;
        if (!tracked) begin
            e.pos = '0; e.line = '0; e.valid = 1'b0;
        end else begin
            a = model_acc(cur_init, cur_step, cur_k);
            e.pos = a[7:0]; e.line = a[18:8]; e.valid = 1'b1;
        end
        return e;
    endfunction

    // Reference for the pass-through video: inputs two edges ago, cleared by reset.
    logic [3*CW+2:0] ref_s1 = '0, ref_s2 = '0;
    always @(posedge VCLK_i) begin
        if (VRST_i) begin
            ref_s1 = '0;
            ref_s2 = '0;
        end else begin
            ref_s2 = ref_s1;
            ref_s1 = {vid.HSYNC_i, vid.VSYNC_i, vid.DE_i, vid.vdata_i};
        end
    end

    // Monitor: pops one expectation per DE_o window and holds it for every pixel in it.
    bit   in_win = 1'b0;
    bit   have   = 1'b0;
    exp_t cur;
    always @(negedge VCLK_i) begin
        chk("vid_delay", 64'({vid.HSYNC_o, vid.VSYNC_o, vid.DE_o, vid.vdata_o}), 64'(ref_s2));
        if (vid.DE_o && !in_win) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                have = 1'b0;
                $display("FAIL sb_underflow: got DE_o window expected none at %0t", $time);
            end else begin
                cur  = sb.pop_front();
                have = 1'b1;
            end
        end
        if (vid.DE_o && have) begin
            chk("sl_rel_pos", 64'(vid.sl_rel_pos_o), 64'(cur.pos));
            chk("sl_src_line", 64'(vid.sl_src_line_o), 64'(cur.line));
            chk("sl_valid", 64'(vid.sl_valid_o), 64'(cur.valid));
        end
        in_win = vid.DE_o;
    end

    task automatic tick();
        @(posedge VCLK_i);
        #1;
        vid.vdata_i = (3*CW)'($urandom);
    endtask

    task automatic line();
        sb.push_back(expect_line());
        for (int unsigned i = 0; i < ACTIVE; i++) begin
            tick();
            vid.DE_i    = 1'b1;
            vid.HSYNC_i = 1'b0;
        end
        for (int unsigned i = 0; i < HBLANK; i++) begin
            tick();
            vid.DE_i    = 1'b0;
            vid.HSYNC_i = (i == 0);
            vid.vphase_init_i = 8'($urandom);
        end
        if (tracked)
            cur_k++;
    endtask

    task automatic frame(input logic [7:0] init, input logic [11:0] step,
                         input int unsigned nlines, input bit fs_on_le);
        vid.vphase_init_i = init;
        vid.vscale_step_i = step;
        if (fs_on_le) begin
            // Tail line whose DE fall coincides with the vsync rise.
            sb.push_back(expect_line());
            for (int unsigned i = 0; i < ACTIVE; i++) begin
                tick();
                vid.DE_i = 1'b1;
            end
        end
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            vid.VSYNC_i = 1'b1;
            vid.DE_i    = 1'b0;
        end
        for (int unsigned i = 0; i < 2; i++) begin
            tick();
            vid.VSYNC_i = 1'b0;
        end
        tracked  = 1'b1;
        cur_init = init;
        cur_step = step;
        cur_k    = 0;
        for (int unsigned n = 0; n < nlines; n++)
            line();
    endtask

    task automatic reset_mid_line();
        sb.push_back(expect_line());
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            vid.DE_i = 1'b1;
        end
        tick();
        VRST_i = 1'b1;
        tick();
        VRST_i = 1'b0;
        @(negedge VCLK_i);
        chk("rst_hsync", 64'(vid.HSYNC_o), 64'd0);
        chk("rst_vsync", 64'(vid.VSYNC_o), 64'd0);
        chk("rst_de", 64'(vid.DE_o), 64'd0);
        chk("rst_vdata", 64'(vid.vdata_o), 64'd0);
        chk("rst_rel_pos", 64'(vid.sl_rel_pos_o), 64'd0);
        chk("rst_src_line", 64'(vid.sl_src_line_o), 64'd0);
        chk("rst_valid", 64'(vid.sl_valid_o), 64'd0);
        tracked = 1'b0;
        sb.push_back(expect_line());
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            vid.DE_i = 1'b1;
        end
        for (int unsigned i = 0; i < HBLANK; i++) begin
            tick();
            vid.DE_i = 1'b0;
        end
    endtask

    initial begin
        vid.HSYNC_i       = 1'b0;
        vid.VSYNC_i       = 1'b0;
        vid.DE_i          = 1'b0;
        vid.vdata_i       = '0;
        vid.vscale_step_i = VSCALE_1TO1;
        vid.vphase_init_i = '0;
        repeat (3) tick();
        VRST_i = 1'b0;
        @(negedge VCLK_i);
        chk("init_valid", 64'(vid.sl_valid_o), 64'd0);
        chk("init_rel_pos", 64'(vid.sl_rel_pos_o), 64'd0);

        line();
        frame(8'h00, 12'h100, 240, 1'b0);
        frame(8'h40, 12'h080, 8, 1'b0);
        frame(8'h00, 12'h155, 4, 1'b0);
        frame(8'h20, 12'h080, 0, 1'b0);
        frame(8'h20, 12'h080, 3, 1'b1);
        frame(8'h00, 12'hFFF, 200, 1'b0);
        frame(8'($urandom), 12'h000, 5, 1'b0);
        frame(8'($urandom), 12'($urandom_range(0, 4095)), 3, 1'b0);
        reset_mid_line();
        line();
        frame(8'h5A, 12'h0C0, 3, 1'b0);
        for (int unsigned f = 0; f < 6; f++)
            frame(8'($urandom), 12'($urandom_range(0, 4095)), $urandom_range(1, 20),
                  1'($urandom_range(0, 1)));

        repeat (10) tick();
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scanline_pos_gen.md
# scanline_pos_gen

Vertical phase tracker that sits directly upstream of the scanline emulation stage. It follows the output video timing and accumulates a fixed-point vertical scale step per active output line. For every output line it delivers the 8-bit relative position of that line inside its source line (`sl_rel_pos`) and the integer source-line index. Video and sync pass through with a fixed delay, so position and pixels arrive aligned.

## Interface
- `VSYNC_ACT_HIGH`, default 1: active level of `VSYNC_i`. 1 = high is active, 0 = low is active.
- `color_width_o`, default from vparams: per-colour width. `vdata` is `3*color_width_o` bits wide.
- `VCLK_i`, in, 1: video clock. Single clock domain.
- `VRST_i`, in, 1: reset. Synchronous and active-high.
- `HSYNC_i`, in, 1: horizontal sync, pass-through.
- `VSYNC_i`, in, 1: vertical sync, pass-through. Also marks frame start.
- `DE_i`, in, 1: data enable.
- `vdata_i`, in, `3*color_width_o`: RGB pixel data.
- `vscale_step_i`, in, 12: input lines advanced per output line, unsigned 4.8 format. `12'h100` = 1:1, `12'h080` = 2x upscale.
- `vphase_init_i`, in, 8: starting fractional phase. Sampled at frame start. Used for field offset in interlaced modes.
- `HSYNC_o`, out, 1: `HSYNC_i` delayed 2 cycles.
- `VSYNC_o`, out, 1: `VSYNC_i` delayed 2 cycles.
- `DE_o`, out, 1: `DE_i` delayed 2 cycles.
- `vdata_o`, out, `3*color_width_o`: `vdata_i` delayed 2 cycles.
- `sl_rel_pos_o`, out, 8: fractional phase of the current output line. Feeds the scanline stage `sl_rel_pos`.
- `sl_src_line_o`, out, 11: integer source-line index of the current output line.
- `sl_valid_o`, out, 1: phase is valid, meaning at least one frame start has been seen since reset. Downstream ANDs it into `sl_en`.

## Operation
- Frame start (FS) is the cycle in which the registered `VSYNC_i` transitions from inactive to active.
- Line end (LE) is the cycle in which the registered `DE_i` falls from 1 to 0.
- Accumulator `acc` is 19 bits in 11.8 format.
- On FS:
  - `acc <= {11'd0, vphase_init_i}`.
  - `sl_valid` is set.
- On LE with no FS in the same cycle: `acc <= acc + {7'd0, vscale_step_i}`.
  - The integer part `acc[18:8]` saturates at `11'h7FF`.
  - Once saturated, the fraction `acc[7:0]` stops changing.
- If FS and LE fall in the same cycle, FS wins and the increment is dropped.
- Output line k of a frame (0-based) therefore carries:
  - `sl_rel_pos_o = (vphase_init + k*step) mod 256`
  - `sl_src_line_o = floor((vphase_init + k*step) / 256)`, saturated at 2047.
- `vscale_step_i = 0` gives a constant phase for all lines. Steps of 16.0 or more are not representable and are not supported.
- `sl_rel_pos_o` and `sl_src_line_o` are registered copies of `acc`. They are updated only while `DE_o` is 0, so they are constant across every active pixel of a line.
- State machine, two states:
  - WAIT_FS: entered at reset. `sl_valid_o = 0`, `acc` held at 0.
  - TRACK: entered on the first FS and left only on reset.
- Reset (`VRST_i` = 1 at a rising edge of `VCLK_i`), at any point including mid-line or mid-frame:
  - All pipeline registers and outputs become 0: `HSYNC_o`, `VSYNC_o`, `DE_o`, `vdata_o`, `sl_rel_pos_o`, `sl_src_line_o`, `sl_valid_o`.
  - The state returns to WAIT_FS.
  - Tracking resumes only at the next FS. A partial frame is never tracked.

## Timing
- Stage 1 registers all inputs and performs edge detection.
- Stage 2 registers outputs and `acc`.
- Latency is exactly 2 `VCLK_i` cycles for sync, DE and `vdata`.
- `acc` updates in the cycle after FS or LE is detected, which is while the delayed `DE_o` of the ended line is already 0.
  - The new phase is therefore visible at `sl_rel_pos_o` before the next `DE_o` rising edge.
  - This holds provided horizontal blanking is at least 2 cycles.
- No handshake. The block is free-running on `VCLK_i` and has no backpressure.
- `vscale_step_i` may change at any time. Changes take effect at the next LE.
- `vphase_init_i` is used only at FS.

## Structure
- Already in shared `n64adv_vparams.vh`: `color_width_o` and the `VDATA_O_*` slice macros.
- To add to `n64adv_vparams.vh` as shared constants:
  - `VSCALE_STEP_W = 12`
  - `VSCALE_FRAC_W = 8`
  - `SL_SRC_LINE_W = 11`
  - `VSCALE_1TO1 = 12'h100`
- One sub-module, `vid_delay_line`, a parameterised N-stage register pipeline for sync, DE and data. It is instantiated with N = 2.
- The phase accumulator and state machine stay in the top module.

## Test plan
- Step `12'h100`, init `8'h00`, 240 lines: `sl_rel_pos_o = 0` on every line; `sl_src_line_o` = 0, 1, …, 239; video data identical after a 2-cycle delay.
- Step `12'h080`, init `8'h40`: `sl_rel_pos_o` sequence is 40, C0, 40, C0…; `sl_src_line_o` sequence is 0, 0, 1, 1, 2…; value constant throughout each `DE_o` window.
- Step `12'h155` (1.333x), 4 lines: `sl_rel_pos_o` = 00, 55, AA, FF and `sl_src_line_o` = 0, 1, 2, 3.
- FS and LE in the same cycle, init `8'h20`, step `12'h080`: next line shows `8'h20`, not `8'hA0`.
- Step `12'hFFF` over 200 lines: `sl_src_line_o` saturates at 2047 and `sl_rel_pos_o` freezes.
- `VRST_i` pulsed mid-line: all outputs are 0 in the next cycle; `sl_valid_o` stays 0 until the next FS and then goes to 1 with `sl_rel_pos_o = vphase_init_i`.
